// File: rtl/dmux4way_dispatcher_if.sv
// Bundle of the source handshake, the four destination channels and the debug
// outputs of the 4-way demux dispatcher.
interface dmux4way_dispatcher_if #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [3:0]           en_mask;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [1:0]           sel;
   logic                 busy;
   logic [CNT_WIDTH-1:0] dispatch_count;

   modport master (
      output in_valid, in_data, en_mask, out_ready,
      input  in_ready, out_valid, out_data, sel, busy, dispatch_count
   );

   modport slave (
      input  in_valid, in_data, en_mask, out_ready,
      output in_ready, out_valid, out_data, sel, busy, dispatch_count
   );
endinterface

// File: rtl/dmux4way_dispatcher.sv
// Round-robin dispatcher: holds one source word and hands it to the next
// enabled channel (a..d), owning the demux select and a dispatch counter.
module dmux4way_dispatcher #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   dmux4way_dispatcher_if.slave  bus
);
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t               state_r, state_s;
   logic [1:0]           ptr_r, ptr_s;
   logic [1:0]           sel_r, sel_s;
   logic [3:0]           out_valid_r, out_valid_s;
   logic [WIDTH-1:0]     data_r, data_s;
   logic                 busy_r, busy_s;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
   logic                 in_ready_s;
   logic [1:0]           target_s;

   // First enabled channel at or after ptr, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic logic [1:0] pick_target(input logic [1:0] ptr, input logic [3:0] mask);
      logic [1:0] idx;
      logic [1:0] res;
      res = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (mask[idx]) begin
            res = idx;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Next-state and next-output logic of the IDLE/SEND handshake.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      sel_s       = sel_r;
      out_valid_s = out_valid_r;
      data_s      = data_r;
      busy_s      = busy_r;
      cnt_s       = cnt_r;
      in_ready_s  = 1'b0;
      target_s    = pick_target(ptr_r, bus.en_mask);
      case (state_r)
         IDLE: begin
            in_ready_s = |bus.en_mask;
            if (bus.in_valid && in_ready_s) begin
               state_s     = SEND;
               sel_s       = target_s;
               out_valid_s = 4'b0001 << target_s;
               data_s      = bus.in_data;
               busy_s      = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            // Only the ready of the channel being driven can complete the handoff.
            if (|(out_valid_r & bus.out_ready)) begin
               state_s     = IDLE;
               ptr_s       = sel_r + 2'd1;
               cnt_s       = cnt_r + CNT_WIDTH'(1'b1);
               out_valid_s = 4'b0000;
               busy_s      = 1'b0;
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s     = IDLE;
            out_valid_s = 4'b0000;
            busy_s      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         ptr_r       <= 2'd0;
         sel_r       <= 2'd0;
         out_valid_r <= 4'b0000;
         data_r      <= '0;
         busy_r      <= 1'b0;
         cnt_r       <= '0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         sel_r       <= sel_s;
         out_valid_r <= out_valid_s;
         data_r      <= data_s;
         busy_r      <= busy_s;
         cnt_r       <= cnt_s;
      end
   end

   assign bus.in_ready       = in_ready_s;
   assign bus.out_valid      = out_valid_r;
   assign bus.out_data       = data_r;
   assign bus.sel            = sel_r;
   assign bus.busy           = busy_r;
   assign bus.dispatch_count = cnt_r;
endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Scoreboard bench for dmux4way_dispatcher: stimulus pushes expected handoffs,
// a negedge monitor pops and compares them when a channel handshake occurs.
module tb_dmux4way_dispatcher;
   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   dmux4way_dispatcher_if #(.WIDTH(16), .CNT_WIDTH(16)) b ();
   dmux4way_dispatcher_if #(.WIDTH(16), .CNT_WIDTH(2))  b2 ();

   dmux4way_dispatcher #(.WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b.slave)
   );

   dmux4way_dispatcher #(.WIDTH(16), .CNT_WIDTH(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2.slave)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] data;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   model_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake is in progress when a valid channel sees its ready.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && |(b.out_valid & b.out_ready)) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_handoff", {28'd0, b.out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_out_valid", {28'd0, b.out_valid}, {28'd0, 4'b0001 << e.ch});
            chk("sb_sel", {30'd0, b.sel}, {30'd0, e.ch});
            chk("sb_out_data", {16'd0, b.out_data}, {16'd0, e.data});
            chk("sb_count_before", {16'd0, b.dispatch_count}, {16'd0, e.cnt});
         end
      end
   end

   // Called and returns just after a rising edge; inputs only change there.
   task automatic send(input logic [15:0] d, input logic [1:0] ch, input bit track);
      exp_t e;
      int t;
      t = 0;
      b.in_data  = d;
      b.in_valid = 1'b1;
      @(negedge clk);
      while (!b.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b.in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         @(posedge clk);
         #1;
         b.in_valid = 1'b0;
      end else begin
         if (track) begin
            e.ch   = ch;
            e.data = d;
            e.cnt  = 16'(model_cnt);
            exp_q.push_back(e);
            model_cnt++;
         end
         @(posedge clk);
         #1;
         b.in_valid = 1'b0;
         @(negedge clk);
         chk("valid_latency", {28'd0, b.out_valid}, {28'd0, 4'b0001 << ch});
         chk("sel_at_send", {30'd0, b.sel}, {30'd0, ch});
         chk("busy_at_send", {31'd0, b.busy}, 32'd1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (b.busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (b.busy) begin
         chk("idle_timeout", 32'd1, 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      b.in_valid   = 1'b0;
      b.in_data    = 16'h0000;
      b.en_mask    = 4'b1111;
      b.out_ready  = 4'b1111;
      b2.in_valid  = 1'b0;
      b2.in_data   = 16'hA5A5;
      b2.en_mask   = 4'b1111;
      b2.out_ready = 4'b1111;

      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {28'd0, b.out_valid}, 32'd0);
      chk("rst_sel", {30'd0, b.sel}, 32'd0);
      chk("rst_busy", {31'd0, b.busy}, 32'd0);
      chk("rst_count", {16'd0, b.dispatch_count}, 32'd0);
      chk("rst_out_data", {16'd0, b.out_data}, 32'd0);
      chk("rst_in_ready", {31'd0, b.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 1: full mask, round robin a,b,c,d,a
      send(16'h0001, 2'd0, 1'b1);
      send(16'h0002, 2'd1, 1'b1);
      send(16'h0003, 2'd2, 1'b1);
      send(16'h0004, 2'd3, 1'b1);
      send(16'h0005, 2'd0, 1'b1);
      wait_idle();
      chk("t1_count", {16'd0, b.dispatch_count}, 32'd5);

      // 2: mask b,d only
      b.en_mask = 4'b1010;
      send(16'h0010, 2'd1, 1'b1);
      send(16'h0011, 2'd3, 1'b1);
      send(16'h0012, 2'd1, 1'b1);
      send(16'h0013, 2'd3, 1'b1);
      wait_idle();
      chk("t2_count", {16'd0, b.dispatch_count}, 32'd9);

      // 3: empty mask blocks acceptance, then only c enabled
      b.en_mask  = 4'b0000;
      b.in_data  = 16'h0C0C;
      b.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_in_ready", {31'd0, b.in_ready}, 32'd0);
         chk("t3_out_valid", {28'd0, b.out_valid}, 32'd0);
         chk("t3_count", {16'd0, b.dispatch_count}, 32'd9);
         @(posedge clk);
         #1;
      end
      b.en_mask = 4'b0100;
      send(16'h0C0C, 2'd2, 1'b1);
      wait_idle();
      chk("t3_count_after", {16'd0, b.dispatch_count}, 32'd10);

      // 4: stalled handoff on a, mask and non-target readies change meanwhile
      b.en_mask   = 4'b0001;
      b.out_ready = 4'b0000;
      send(16'hBEEF, 2'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_out_valid", {28'd0, b.out_valid}, 32'd1);
         chk("t4_out_data", {16'd0, b.out_data}, 32'h0000BEEF);
         chk("t4_busy", {31'd0, b.busy}, 32'd1);
         chk("t4_in_ready", {31'd0, b.in_ready}, 32'd0);
         chk("t4_sel", {30'd0, b.sel}, 32'd0);
         @(posedge clk);
         #1;
         if (i == 1) begin
            b.en_mask   = 4'b0010;
            b.out_ready = 4'b1110;
         end
      end
      b.out_ready = 4'b1111;
      wait_idle();
      send(16'h00B0, 2'd1, 1'b1);
      wait_idle();
      chk("t4_count", {16'd0, b.dispatch_count}, 32'd12);

      // 5: reset while a word for c is pending
      b.en_mask   = 4'b1111;
      b.out_ready = 4'b0000;
      send(16'h1234, 2'd2, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", {28'd0, b.out_valid}, 32'd0);
      chk("t5_sel", {30'd0, b.sel}, 32'd0);
      chk("t5_busy", {31'd0, b.busy}, 32'd0);
      chk("t5_count", {16'd0, b.dispatch_count}, 32'd0);
      model_cnt = 0;
      @(posedge clk);
      #1;
      b.out_ready = 4'b1111;
      send(16'h5678, 2'd0, 1'b1);
      wait_idle();
      chk("t5_count_after", {16'd0, b.dispatch_count}, 32'd1);

      // 6: 2-bit counter wraps
      b2.in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         t = 0;
         @(negedge clk);
         while (b2.out_valid == 4'b0000 && t < 10) begin
            @(negedge clk);
            t++;
         end
         if (b2.out_valid == 4'b0000) begin
            chk("t6_valid_timeout", 32'd0, 32'd1);
         end
         @(negedge clk);
         chk("t6_count", {30'd0, b2.dispatch_count}, {30'd0, 2'(k + 1)});
      end
      @(posedge clk);
      #1 b2.in_valid = 1'b0;

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
